seat_find: RTL and testbench

Reverse-lookup engine for the seat table: given a student number, it scans the 32-entry seat→student table through the table's read port and returns the seat holding that student. It is the read-side counterpart of the seat-assignment write path, sitting between the query/display logic and the seat table RAM. It performs one search at a time under a req/busy/done handshake.

---
 rtl/seat_pkg.sv | 29 ++
 rtl/seat_find.sv | 169 ++++++++++++++++
 tb/tb_seat_find.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seat_pkg.sv
// Shared definitions for the seat table: geometry constants, the reverse
// lookup FSM state type, and the student/seat number types also used by the
// seat-assignment writer.
package seat_pkg;

  localparam int SEATS  = 32;
  localparam int STU_W  = 25;
  localparam int SEAT_W = 8;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } seat_find_state_t;

  typedef logic [STU_W-1:0]  student_no_t;
  typedef logic [SEAT_W-1:0] seat_no_t;

  localparam seat_no_t LAST_SEAT = seat_no_t'(SEATS - 1);

  // A table word holds a student only when the bits above the student field
  // are clear; anything else is a stale or foreign encoding and never matches.
  function automatic logic word_matches(input logic [WORD_W-1:0] word,
                                        input student_no_t       key);
    return (word[STU_W-1:0] == key) && (word[WORD_W-1:STU_W] == '0);
  endfunction

endpackage

// File: rtl/seat_find.sv
// seat_find: reverse lookup of a student number in the 32-entry seat table.
// Issues one table read per cycle starting at seat 0; read data returns one
// cycle later and is compared against the captured key.
//
// Optional feature macro: SEAT_FIND_DUP_EN
//   defined   : always scans all seats, reports the lowest match and flags
//               any further match on dup_seat_find.
//   undefined : stops at the first match; dup_seat_find is tied low.
//
// Handshake: req_seat_find is sampled only in IDLE; the request is taken on
// that edge, busy_seat_find stays high until and including the single
// done_seat_find cycle, and requests seen while busy are dropped (the
// requester must hold or re-issue req after done). Results are held from
// done until the next accepted request.
module seat_find
  import seat_pkg::*;
(
  input  logic              clk_seat_find,
  input  logic              rst_n_seat_find,
  input  logic              req_seat_find,
  input  student_no_t       Student_No_seat_find,
  output logic              busy_seat_find,
  output logic              done_seat_find,
  output logic              found_seat_find,
  output seat_no_t          Seat_No_seat_find,
  output logic              dup_seat_find,
  output logic              rd_en_seat_find,
  output seat_no_t          rd_addr_seat_find,
  input  logic [WORD_W-1:0] rd_data_seat_find
);

  seat_find_state_t state_q, state_d;
  student_no_t      key_q, key_d;
  logic             rd_en_q, rd_en_d;
  seat_no_t         rd_addr_q, rd_addr_d;
  // Read pipeline: cmp_vld_q marks that rd_data carries the word for cmp_addr_q.
  logic             cmp_vld_q, cmp_vld_d;
  seat_no_t         cmp_addr_q, cmp_addr_d;
  logic             found_q, found_d;
  seat_no_t         seat_q, seat_d;
  logic             dup_q, dup_d;

  logic             hit;
  logic             scan_end;

  assign hit = cmp_vld_q && word_matches(rd_data_seat_find, key_q);

  // Next-state, read issue and result update.
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    rd_en_d    = rd_en_q;
    rd_addr_d  = rd_addr_q;
    cmp_vld_d  = 1'b0;
    cmp_addr_d = cmp_addr_q;
    found_d    = found_q;
    seat_d     = seat_q;
    dup_d      = dup_q;
    scan_end   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_seat_find) begin
          key_d     = Student_No_seat_find;
          found_d   = 1'b0;
          seat_d    = '0;
          dup_d     = 1'b0;
          state_d   = SCAN;
          // Key 0 marks an empty seat and is never searched for: SCAN is
          // entered with nothing in flight and falls straight through to DONE.
          rd_en_d   = (Student_No_seat_find != '0);
          rd_addr_d = '0;
        end
      end

      SCAN: begin
        cmp_vld_d  = rd_en_q;
        cmp_addr_d = rd_addr_q;

        if (rd_en_q) begin
          if (rd_addr_q == LAST_SEAT) begin
            rd_en_d   = 1'b0;
            rd_addr_d = '0;
          end else begin
            rd_addr_d = rd_addr_q + seat_no_t'(1);
          end
        end

        if (hit) begin
          if (!found_q) begin
            found_d = 1'b1;
            seat_d  = cmp_addr_q;
          end
`ifdef SEAT_FIND_DUP_EN
          else begin
            dup_d = 1'b1;
          end
`else
          // First match wins; the read already issued for the next seat is
          // simply never compared.
          scan_end = 1'b1;
`endif
        end

        if (cmp_vld_q && (cmp_addr_q == LAST_SEAT)) begin
          scan_end = 1'b1;
        end
        if (!rd_en_q && !cmp_vld_q) begin
          scan_end = 1'b1;
        end

        if (scan_end) begin
          state_d   = DONE;
          rd_en_d   = 1'b0;
          rd_addr_d = '0;
          cmp_vld_d = 1'b0;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        rd_en_d   = 1'b0;
        rd_addr_d = '0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any search in progress.
  always_ff @(posedge clk_seat_find or negedge rst_n_seat_find) begin
    if (!rst_n_seat_find) begin
      state_q    <= IDLE;
      key_q      <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_addr_q <= '0;
      found_q    <= 1'b0;
      seat_q     <= '0;
      dup_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_addr_q <= cmp_addr_d;
      found_q    <= found_d;
      seat_q     <= seat_d;
      dup_q      <= dup_d;
    end
  end

  assign busy_seat_find    = (state_q != IDLE);
  assign done_seat_find    = (state_q == DONE);
  assign found_seat_find   = found_q;
  assign Seat_No_seat_find = seat_q;
`ifdef SEAT_FIND_DUP_EN
  assign dup_seat_find     = dup_q;
`else
  assign dup_seat_find     = 1'b0;
`endif
  assign rd_en_seat_find   = rd_en_q;
  assign rd_addr_seat_find = rd_addr_q;

endmodule

// File: tb/tb_seat_find.sv
// Bench for seat_find: table-driven vectors, hand sequences for reset and
// request corner cases, and randomized tables checked against a reference.
module tb_seat_find;
  import seat_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0;
  student_no_t       key = '0;
  logic              busy, done, found, dup, rd_en;
  seat_no_t          seat_no, rd_addr;
  logic [WORD_W-1:0] rd_data = '0;

  logic [WORD_W-1:0] mem [SEATS];

  int n_checks = 0;
  int n_fail   = 0;

  seat_find dut (
    .clk_seat_find        (clk),
    .rst_n_seat_find      (rst_n),
    .req_seat_find        (req),
    .Student_No_seat_find (key),
    .busy_seat_find       (busy),
    .done_seat_find       (done),
    .found_seat_find      (found),
    .Seat_No_seat_find    (seat_no),
    .dup_seat_find        (dup),
    .rd_en_seat_find      (rd_en),
    .rd_addr_seat_find    (rd_addr),
    .rd_data_seat_find    (rd_data)
  );

  // Clock
  always #5 clk = ~clk;

  // Synchronous-read table model
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr[4:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_background();
    for (int i = 0; i < SEATS; i++) mem[i] = {7'b0, 25'h10_0000 + 25'(i)};
  endtask

  // Reference: a seat holds the key when its whole word equals the
  // zero-extended key. Latency counted in edges after acceptance.
  task automatic model(input student_no_t k, output logic f, output seat_no_t s,
                       output logic d, output int lat, output int nreads);
    int hits[$];
    hits = {};
    f = 1'b0; s = '0; d = 1'b0;
    if (k == '0) begin
      lat = 1; nreads = 0;
      return;
    end
    for (int i = 0; i < SEATS; i++)
      if (mem[i] == {7'b0, k}) hits.push_back(i);
    if (hits.size() > 0) begin
      f = 1'b1;
      s = seat_no_t'(hits[0]);
    end
`ifdef SEAT_FIND_DUP_EN
    d = (hits.size() > 1);
    lat = SEATS + 1; nreads = SEATS;
`else
    if (f) begin
      lat = hits[0] + 2;
      nreads = (hits[0] + 2 > SEATS) ? SEATS : hits[0] + 2;
    end else begin
      lat = SEATS + 1; nreads = SEATS;
    end
`endif
  endtask

  // One search: issue req, follow it cycle by cycle, compare results.
  task automatic run_search(input student_no_t k, input bit poke, input string tag,
                            input logic ef, input seat_no_t es, input logic ed,
                            input int elat, input int ereads);
    int n, reads, bad_addr, bad_busy, lat_seen;
    reads = 0; bad_addr = 0; bad_busy = 0; lat_seen = -1;
    @(negedge clk);
    req = 1'b1; key = k;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    key = student_no_t'($urandom);
    for (n = 0; n < 60; n++) begin
      if (!busy) bad_busy++;
      if (rd_en) begin
        reads++;
        if (rd_addr != seat_no_t'(n)) bad_addr++;
      end
      if (poke && n == 0) req = 1'b1;
      if (poke && n == 1) req = 1'b0;
      if (done) begin
        lat_seen = n;
        break;
      end
      @(negedge clk);
    end
    req = 1'b0;
    check({tag, "_latency"}, lat_seen, elat);
    check({tag, "_found"}, found, ef);
    check({tag, "_seat"}, seat_no, es);
    check({tag, "_dup"}, dup, ed);
    check({tag, "_reads"}, reads, ereads);
    check({tag, "_addr_seq_errs"}, bad_addr, 0);
    check({tag, "_busy_gaps"}, bad_busy, 0);
    @(negedge clk);
    check({tag, "_idle_after"}, {busy, done}, 2'b00);
    check({tag, "_held"}, {found, seat_no, dup}, {ef, es, ed});
  endtask

  typedef struct {
    student_no_t       k;
    int                s1;
    logic [WORD_W-1:0] w1;
    int                s2;
    logic [WORD_W-1:0] w2;
    bit                poke;
    logic              f;
    seat_no_t          seat;
    logic              d;
    int                lat;
    int                reads;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic     mf, md;
    seat_no_t ms;
    int       mlat, mreads;
    int       n;

    // Reset block
    fill_background();
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, found, seat_no, dup, rd_en, rd_addr}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table
    vecs[0] = '{25'h1234, 5, 32'h0000_1234, -1, 32'h0, 1'b0, 1'b1, 8'd5, 1'b0,
`ifdef SEAT_FIND_DUP_EN
                33, 32};
`else
                7, 7};
`endif
    vecs[1] = '{25'h5555, -1, 32'h0, -1, 32'h0, 1'b0, 1'b0, 8'd0, 1'b0, 33, 32};
    vecs[2] = '{25'h0, 2, 32'h0, -1, 32'h0, 1'b0, 1'b0, 8'd0, 1'b0, 1, 0};
    vecs[3] = '{25'hA_BCDE, 3, 32'h000A_BCDE, 20, 32'h000A_BCDE, 1'b0, 1'b1, 8'd3,
`ifdef SEAT_FIND_DUP_EN
                1'b1, 33, 32};
`else
                1'b0, 5, 5};
`endif
    vecs[4] = '{25'h42, 7, 32'h0200_0042, -1, 32'h0, 1'b1, 1'b0, 8'd0, 1'b0, 33, 32};
    vecs[5] = '{25'h1, 0, 32'h0000_0001, -1, 32'h0, 1'b0, 1'b1, 8'd0, 1'b0,
`ifdef SEAT_FIND_DUP_EN
                33, 32};
`else
                2, 2};
`endif
    vecs[6] = '{25'h1FF_FFFF, 31, 32'h01FF_FFFF, -1, 32'h0, 1'b0, 1'b1, 8'd31, 1'b0, 33, 32};
    vecs[7] = '{25'h42, 7, 32'h0200_0042, 9, 32'h0000_0042, 1'b0, 1'b1, 8'd9, 1'b0,
`ifdef SEAT_FIND_DUP_EN
                33, 32};
`else
                11, 11};
`endif

    for (int i = 0; i < 8; i++) begin
      fill_background();
      if (vecs[i].s1 >= 0) mem[vecs[i].s1] = vecs[i].w1;
      if (vecs[i].s2 >= 0) mem[vecs[i].s2] = vecs[i].w2;
      run_search(vecs[i].k, vecs[i].poke, $sformatf("vec%0d", i), vecs[i].f,
                 vecs[i].seat, vecs[i].d, vecs[i].lat, vecs[i].reads);
    end

    // Reset in the middle of a scan at address 10
    fill_background();
    mem[25] = 32'h0000_7777;
    @(negedge clk);
    req = 1'b1; key = 25'h7777;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (10) @(negedge clk);
    check("midscan_addr", {rd_en, rd_addr}, {1'b1, 8'd10});
    rst_n = 1'b0;
    #1;
    check("midscan_reset_outputs", {busy, done, found, seat_no, dup, rd_en, rd_addr}, '0);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    check("reset_no_done", n, 0);
    rst_n = 1'b1;
    run_search(25'h7777, 1'b0, "after_reset", 1'b1, 8'd25, 1'b0,
`ifdef SEAT_FIND_DUP_EN
               33, 32);
`else
               27, 27);
`endif

    // req held high: re-accepted at the first edge spent in IDLE
    @(negedge clk);
    req = 1'b1; key = '0;
    @(posedge clk);
    @(negedge clk);
    check("held_c0", {busy, done}, 2'b10);
    @(negedge clk);
    check("held_c1", {busy, done}, 2'b11);
    @(negedge clk);
    check("held_c2", {busy, done}, 2'b00);
    @(negedge clk);
    check("held_c3", {busy, done}, 2'b10);
    req = 1'b0;
    repeat (4) @(negedge clk);
    check("held_settle", {busy, done}, 2'b00);

    // Randomized tables against the reference
    for (int t = 0; t < 24; t++) begin
      student_no_t rk;
      int nplant;
      for (int i = 0; i < SEATS; i++) begin
        mem[i] = $urandom;
        if ($urandom_range(0, 1) == 0) mem[i][31:25] = 7'b0;
      end
      rk = student_no_t'($urandom_range(1, 32'h1FF_FFFF));
      if ($urandom_range(0, 9) == 0) rk = '0;
      nplant = $urandom_range(0, 3);
      for (int p = 0; p < nplant; p++) begin
        int s;
        s = $urandom_range(0, SEATS - 1);
        if ($urandom_range(0, 3) == 0) mem[s] = {7'($urandom_range(1, 127)), rk};
        else mem[s] = {7'b0, rk};
      end
      model(rk, mf, ms, md, mlat, mreads);
      run_search(rk, t[0], $sformatf("rand%0d", t), mf, ms, md, mlat, mreads);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
